// File: rtl/seven_segment_scanner.sv
// Multiplexed hex 7-segment driver: per-frame input snapshot, leading-zero suppression,
// PWM brightness and a dead-time gap at the start of every digit slot; outputs are registered.
module seven_segment_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 40000,
  parameter int DEAD_CYCLES    = 16,
  parameter bit SEL_ACTIVE_LOW = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [NUM_DIGITS-1:0]         dp_mask,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  input  logic                          lz_en,
  input  logic [3:0]                    brightness,
  output logic [NUM_DIGITS-1:0]         segment_selection,
  output logic [7:0]                    segment_data,
  output logic [$clog2(NUM_DIGITS)-1:0] current_digit,
  output logic                          frame_start
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW}};
  localparam logic [7:0]            SEG_OFF = {8{SEG_ACTIVE_LOW}};

  logic [PRE_W-1:0]        prescaler;
  logic [IDX_W-1:0]        scan_digit;
  logic [3:0]              pwm_cnt;
  logic                    load_pending;

  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic                    sh_lz_en;
  logic [3:0]              sh_bright;

  logic                    slot_wrap;
  logic                    load_shadow;
  logic [NUM_DIGITS-1:0]   suppress;
  logic                    zero_chain;
  logic [3:0]              cur_val;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    cur_sup;
  logic                    dark;
  logic [NUM_DIGITS-1:0]   sel_nxt;
  logic [7:0]              seg_nxt;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign slot_wrap   = (prescaler == PRE_W'(CLK_DIV - 1));
  assign load_shadow = load_pending || (slot_wrap && (scan_digit == IDX_W'(NUM_DIGITS - 1)));

  always_comb begin
    suppress   = '0;
    zero_chain = 1'b1;
    cur_val    = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    cur_sup    = 1'b0;
    sel_nxt    = '0;
    seg_nxt    = 8'h00;

    // A zero digit stays dark while everything above it is zero too; its own dp keeps it lit.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_chain = zero_chain && (sh_digits[4*i +: 4] == 4'h0);
      if (i != 0) suppress[i] = sh_lz_en && zero_chain && !sh_dp[i];
    end

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_digit == IDX_W'(i)) begin
        cur_val   = sh_digits[4*i +: 4];
        cur_dp    = sh_dp[i];
        cur_blank = sh_blank[i];
        cur_sup   = suppress[i];
      end
    end

    dark = cur_blank || cur_sup || (prescaler < PRE_W'(DEAD_CYCLES)) || !(pwm_cnt < sh_bright);

    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_nxt[i] = !dark && (scan_digit == IDX_W'(i));
    end
    if (!dark) seg_nxt = {cur_dp, hex_decode(cur_val)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler         <= '0;
      scan_digit        <= '0;
      pwm_cnt           <= 4'd0;
      load_pending      <= 1'b1;
      sh_digits         <= '0;
      sh_dp             <= '0;
      sh_blank          <= '0;
      sh_lz_en          <= 1'b0;
      sh_bright         <= 4'd0;
      frame_start       <= 1'b0;
      segment_selection <= SEL_OFF;
      segment_data      <= SEG_OFF;
      current_digit     <= '0;
    end else begin
      prescaler <= slot_wrap ? '0 : prescaler + 1'b1;
      if (slot_wrap) begin
        scan_digit <= (scan_digit == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_digit + 1'b1;
      end
      pwm_cnt <= (pwm_cnt == 4'd14) ? 4'd0 : pwm_cnt + 4'd1;

      load_pending <= 1'b0;
      frame_start  <= load_shadow;
      if (load_shadow) begin
        sh_digits <= digits;
        sh_dp     <= dp_mask;
        sh_blank  <= blank_mask;
        sh_lz_en  <= lz_en;
        sh_bright <= brightness;
      end

      segment_selection <= sel_nxt ^ SEL_OFF;
      segment_data      <= seg_nxt ^ SEG_OFF;
      current_digit     <= scan_digit;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner: a frame-level vector table plus hand-written
// sequences for mid-frame input changes, PWM duty, active-low polarity and mid-scan reset.
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp_mask = 4'h0;
  logic [3:0]  blank_mask = 4'h0;
  logic        lz_en = 1'b0;
  logic [3:0]  brightness = 4'hF;

  logic [3:0]  sel, sel_al;
  logic [7:0]  seg, seg_al;
  logic [1:0]  cur, cur_al;
  logic        fs, fs_al;

  int total = 0;
  int bad = 0;

  int          lit_cnt [4];
  logic [7:0]  seg_seen [4];
  int          seg_var, hot_bad, dark_bad, cur_bad;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz;
    logic [31:0] exp_seg;  // {d3,d2,d1,d0}, 00 = digit dark all frame
  } vec_t;

  vec_t vecs [9];

  seven_segment_scanner #(.NUM_DIGITS(4), .CLK_DIV(8), .DEAD_CYCLES(2),
                          .SEL_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_mask(dp_mask), .blank_mask(blank_mask),
    .lz_en(lz_en), .brightness(brightness), .segment_selection(sel), .segment_data(seg),
    .current_digit(cur), .frame_start(fs));

  seven_segment_scanner #(.NUM_DIGITS(4), .CLK_DIV(8), .DEAD_CYCLES(2),
                          .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_mask(dp_mask), .blank_mask(blank_mask),
    .lz_en(lz_en), .brightness(brightness), .segment_selection(sel_al), .segment_data(seg_al),
    .current_digit(cur_al), .frame_start(fs_al));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_fs(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs && n < 60);
    check({name, " frame_start"}, 32'(fs), 32'd1);
  endtask

  task automatic observe(input int cycles);
    for (int d = 0; d < 4; d++) begin
      lit_cnt[d]  = 0;
      seg_seen[d] = 8'h00;
    end
    seg_var = 0; hot_bad = 0; dark_bad = 0; cur_bad = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (sel == 4'b0000) begin
        if (seg != 8'h00) dark_bad++;
      end else if ($countones(sel) != 1) begin
        hot_bad++;
      end else begin
        for (int d = 0; d < 4; d++) begin
          if (sel[d]) begin
            if (lit_cnt[d] > 0 && seg_seen[d] != seg) seg_var++;
            seg_seen[d] = seg;
            lit_cnt[d]++;
            if (cur != 2'(d)) cur_bad++;
          end
        end
      end
    end
  endtask

  function automatic int lit_sum();
    return lit_cnt[0] + lit_cnt[1] + lit_cnt[2] + lit_cnt[3];
  endfunction

  initial begin
    int n, n_al, bad_al;
    logic found;

    vecs[0] = '{16'h1234, 4'b0000, 4'b0000, 1'b0, 32'h065B4F66};
    vecs[1] = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 32'h00006D3F};
    vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 32'h0000003F};
    vecs[3] = '{16'h0000, 4'b0100, 4'b0000, 1'b1, 32'h00BF003F};
    vecs[4] = '{16'h89AB, 4'b1010, 4'b0001, 1'b0, 32'hFF6FF700};
    vecs[5] = '{16'hCDEF, 4'b0000, 4'b0100, 1'b1, 32'h39007971};
    vecs[6] = '{16'h0007, 4'b0000, 4'b0000, 1'b0, 32'h3F3F3F07};
    vecs[7] = '{16'h0100, 4'b0000, 4'b0000, 1'b1, 32'h00063F3F};
    vecs[8] = '{16'h000A, 4'b0001, 4'b0000, 1'b0, 32'h3F3F3FF7};

    // reset state
    repeat (2) @(negedge clk);
    check("rst sel", 32'(sel), 32'h0);
    check("rst seg", 32'(seg), 32'h0);
    check("rst cur", 32'(cur), 32'h0);
    check("rst fs", 32'(fs), 32'h0);
    check("rst sel_al", 32'(sel_al), 32'hF);
    check("rst seg_al", 32'(seg_al), 32'hFF);
    check("rst cur_fs_al", {30'(cur_al), 1'b0, fs_al}, 32'h0);
    rst_n = 1'b1;

    // frame-level table, full brightness
    for (int v = 0; v < 9; v++) begin
      digits = vecs[v].digits; dp_mask = vecs[v].dp; blank_mask = vecs[v].blank;
      lz_en = vecs[v].lz; brightness = 4'hF;
      wait_fs($sformatf("vec%0d", v));
      observe(32);
      for (int d = 0; d < 4; d++) begin
        check($sformatf("vec%0d d%0d lit", v, d), 32'(lit_cnt[d]),
              (vecs[v].exp_seg[8*d +: 8] == 8'h00) ? 32'd0 : 32'd6);
        check($sformatf("vec%0d d%0d seg", v, d), 32'(seg_seen[d]), 32'(vecs[v].exp_seg[8*d +: 8]));
      end
      check($sformatf("vec%0d glitch", v), 32'(seg_var + hot_bad + dark_bad + cur_bad), 32'd0);
    end

    // mid-frame change is held off until the next snapshot
    digits = 16'h1111; dp_mask = 4'h0; blank_mask = 4'h0; lz_en = 1'b0;
    wait_fs("t3 a");
    observe(12);
    digits = 16'h2222;
    observe(19);
    for (int d = 1; d < 4; d++) check($sformatf("t3 old d%0d", d), 32'(seg_seen[d]), 32'h06);
    check("t3 old stable", 32'(seg_var), 32'd0);
    wait_fs("t3 b");
    observe(32);
    for (int d = 0; d < 4; d++) check($sformatf("t3 new d%0d", d), 32'(seg_seen[d]), 32'h5B);

    // brightness
    digits = 16'h1234; brightness = 4'd0;
    wait_fs("t4 off");
    observe(32);
    check("t4 bright0 lit", 32'(lit_sum()), 32'd0);
    brightness = 4'd7;
    wait_fs("t4 b7");
    observe(120);  // 8 and 15 coprime: each (slot phase, pwm) pair once
    check("t4 bright7 lit", 32'(lit_sum()), 32'd42);
    check("t4 bright7 onehot", 32'(hot_bad + dark_bad), 32'd0);

    // active-low polarity
    digits = 16'h000A; dp_mask = 4'b0001; brightness = 4'hF;
    wait_fs("t5");
    n_al = 0; bad_al = 0;
    repeat (32) begin
      @(negedge clk);
      if (sel_al == 4'b1110) begin
        n_al++;
        if (seg_al != 8'h08) bad_al++;
      end else if (sel_al == 4'b1111 && seg_al != 8'hFF) begin
        bad_al++;
      end
    end
    check("t5 d0 lit", 32'(n_al), 32'd6);
    check("t5 seg_al", 32'(bad_al), 32'd0);

    // reset mid-scan
    digits = 16'h1234; dp_mask = 4'h0;
    n = 0; found = 1'b0;
    while (!found && n < 100) begin
      @(negedge clk);
      n++;
      found = (cur == 2'd2) && (sel == 4'b0100);
    end
    check("t6 reach digit2", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6 sel off", 32'(sel), 32'h0);
    check("t6 seg off", 32'(seg), 32'h0);
    check("t6 sel_al off", 32'(sel_al), 32'hF);
    check("t6 cur", 32'(cur), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6 fs after release", 32'(fs), 32'd1);
    check("t6 cur after release", 32'(cur), 32'd0);
    @(negedge clk);
    check("t6 fs one cycle", 32'(fs), 32'd0);
    n = 0;
    while (sel == 4'b0000 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t6 first slot", 32'(sel), 32'b0001);
    check("t6 first seg", 32'(seg), 32'h66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
